fetch_stage: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the combinational instruction ROM (8-bit word address, 16-bit instruction word).
- Registers the returned instruction into an IF/ID pipeline register with a valid flag for decode.
- Handles stall from decode, redirect from execute (branches), zero-bubble predecoded jumps, halt, and a fetch counter.

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly in front of a combinational
// instruction ROM. It owns the program counter and presents it on
// imem_addr. It registers the returned word into the IF/ID pipeline
// register (if_instr / if_pc / if_valid) for decode.
//
// Handshake: decode accepts the IF/ID register on every clock edge where
// stall=0. While stall=1 the register, pc and fetch_cnt hold. A redirect
// from execute always wins and flushes the slot. Only valid/ready-style
// signal here is if_valid (valid) paired with !stall (ready).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr         word address to instruction memory (== pc)
//   imem_iw           instruction word returned combinationally
//   stall             decode cannot accept; hold everything
//   redirect_valid    branch taken / flush from execute
//   redirect_pc       redirect target
//   halt_req          stop fetching after the current cycle
//   if_valid          IF/ID register holds a live instruction
//   if_instr, if_pc   registered instruction and its fetch address
//   halted            FSM is in HALTED
//   fetch_cnt         saturating count of issued instructions
//   dbg_state         raw FSM state (BOOT=0, RUN=1, HALTED=2)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          IW_W     = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [3:0]           JMP_OPC  = 4'b0010
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [IW_W-1:0]   imem_iw,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              if_valid,
  output logic [IW_W-1:0]   if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic [15:0]       fetch_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_if_valid;
  logic [IW_W-1:0]   r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_halted;
  logic [15:0]       r_fetch_cnt;

  logic              w_is_jmp;
  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_pc_issue;
  logic [15:0]       w_cnt_inc;

  // Predecode of the word currently being fetched: an unconditional jump
  // steers pc straight to its target so no bubble is inserted.
  assign w_is_jmp   = (imem_iw[IW_W-1 -: 4] == JMP_OPC);
  assign w_pc_seq   = r_pc + ADDR_W'(1);
  assign w_pc_issue = w_is_jmp ? imem_iw[ADDR_W-1:0] : w_pc_seq;
  assign w_cnt_inc  = (r_fetch_cnt == 16'hFFFF) ? r_fetch_cnt : r_fetch_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_instr  <= '0;
      r_if_pc     <= '0;
      r_halted    <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      case (r_state)
        // One dead cycle after reset release; nothing is issued and
        // redirect/halt requests are ignored.
        ST_BOOT: begin
          r_state <= ST_RUN;
        end

        ST_RUN: begin
          if (redirect_valid) begin
            // Word at the old pc is dropped; one invalid slot follows.
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
          end else if (halt_req && !stall) begin
            r_if_valid <= 1'b0;
            r_halted   <= 1'b1;
            r_state    <= ST_HALTED;
          end else if (!stall) begin
            r_if_instr  <= imem_iw;
            r_if_pc     <= r_pc;
            r_if_valid  <= 1'b1;
            r_fetch_cnt <= w_cnt_inc;
            r_pc        <= w_pc_issue;
          end
        end

        ST_HALTED: begin
          r_if_valid <= 1'b0;
          if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
            r_state  <= ST_RUN;
          end
        end

        default: begin
          r_state    <= ST_BOOT;
          r_if_valid <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  // imem_addr is a pure register copy: no combinational path from
  // stall/redirect into the ROM address.
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign halted    = r_halted;
  assign fetch_cnt = r_fetch_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed scenarios followed by a randomized run compared against a
// cycle-level behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_iw;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic [1:0]  dbg_state;

  logic [15:0] mem [256];

  int n_pass;
  int n_total;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_iw = mem[imem_addr];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_iw        (imem_iw),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .fetch_cnt      (fetch_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [7:0] rp, input logic h);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rp;
    halt_req       = h;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = booting, 1 = running, 2 = halted
  int          m_mode;
  int          m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  int          m_ipc;
  int          m_cnt;
  logic        m_halted;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_valid = 1'b0; m_instr = 16'h0;
    m_ipc = 0; m_cnt = 0; m_halted = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic r, input int rp, input logic h);
    logic [15:0] w;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_valid = 1'b0;
      if (r) begin
        m_pc = rp; m_mode = 1; m_halted = 1'b0;
      end
    end else begin
      if (r) begin
        m_pc = rp; m_valid = 1'b0;
      end else if (h && !s) begin
        m_valid = 1'b0; m_mode = 2; m_halted = 1'b1;
      end else if (!s) begin
        w       = mem[m_pc];
        m_instr = w;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (w[15:12] == 4'd2) m_pc = int'(w[7:0]);
        else                  m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    n_total++;
    if ({if_valid, if_instr, if_pc, fetch_cnt, halted, imem_addr} !== 50'h0) begin
      $display("FAIL reset: valid=%0b instr=%h pc=%h cnt=%0d halted=%0b addr=%h, required all zero",
               if_valid, if_instr, if_pc, fetch_cnt, halted, imem_addr);
    end else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential_and_stall();
    tick();  // boot cycle
    n_total++;
    if (if_valid !== 1'b0 || imem_addr !== 8'h00) $display("FAIL boot_slot: valid=%0b addr=%h, required 0/00", if_valid, imem_addr);
    else n_pass++;
    tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 16'h0440)
      $display("FAIL first_issue: valid=%0b pc=%h instr=%h, required 1/00/0440", if_valid, if_pc, if_instr);
    else n_pass++;
    tick();
    n_total++;
    if (if_pc !== 8'h01 || if_instr !== 16'h460E) $display("FAIL issue_1: pc=%h instr=%h, required 01/460e", if_pc, if_instr);
    else n_pass++;
    tick();
    n_total++;
    if (if_pc !== 8'h02 || if_instr !== 16'hB0E1 || fetch_cnt !== 16'd3)
      $display("FAIL issue_2: pc=%h instr=%h cnt=%0d, required 02/b0e1/3", if_pc, if_instr, fetch_cnt);
    else n_pass++;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (if_pc !== 8'h02 || if_instr !== 16'hB0E1 || fetch_cnt !== 16'd3 || imem_addr !== 8'h03 || if_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h cnt=%0d addr=%h valid=%0b, required 02/b0e1/3/03/1",
                 i, if_pc, if_instr, fetch_cnt, imem_addr, if_valid);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    n_total++;
    if (if_pc !== 8'h03 || fetch_cnt !== 16'd4) $display("FAIL stall_resume: pc=%h cnt=%0d, required 03/4", if_pc, fetch_cnt);
    else n_pass++;
  endtask

  task automatic test_jump();
    tick();
    n_total++;
    if (if_pc !== 8'h04 || if_instr !== 16'h2000 || imem_addr !== 8'h00)
      $display("FAIL jump_issue: pc=%h instr=%h addr=%h, required 04/2000/00", if_pc, if_instr, imem_addr);
    else n_pass++;
    tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 16'h0440 || fetch_cnt !== 16'd6)
      $display("FAIL jump_target: valid=%0b pc=%h instr=%h cnt=%0d, required 1/00/0440/6", if_valid, if_pc, if_instr, fetch_cnt);
    else n_pass++;
  endtask

  task automatic test_redirect_over_stall();
    drive(1'b1, 1'b1, 8'h40, 1'b0);
    tick();
    n_total++;
    if (if_valid !== 1'b0 || imem_addr !== 8'h40) $display("FAIL redirect_flush: valid=%0b addr=%h, required 0/40", if_valid, imem_addr);
    else n_pass++;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 8'h40 || if_instr !== 16'h1234)
      $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, required 1/40/1234", if_valid, if_pc, if_instr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    n_total++;
    if (if_pc !== 8'hFF || if_instr !== 16'h5678 || imem_addr !== 8'h00)
      $display("FAIL pc_wrap: pc=%h instr=%h addr=%h, required ff/5678/00", if_pc, if_instr, imem_addr);
    else n_pass++;
  endtask

  task automatic test_halt();
    logic [7:0] frozen;
    frozen = imem_addr;
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    n_total++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== frozen)
      $display("FAIL halt_enter: halted=%0b valid=%0b addr=%h, required 1/0/%h", halted, if_valid, imem_addr, frozen);
    else n_pass++;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    n_total++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== frozen)
      $display("FAIL halt_stay: halted=%0b valid=%0b addr=%h, required 1/0/%h", halted, if_valid, imem_addr, frozen);
    else n_pass++;
    drive(1'b0, 1'b1, 8'h10, 1'b0);
    tick();
    n_total++;
    if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 8'h10)
      $display("FAIL halt_exit: halted=%0b valid=%0b addr=%h, required 0/0/10", halted, if_valid, imem_addr);
    else n_pass++;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 8'h10 || if_instr !== 16'h0ABC)
      $display("FAIL halt_resume: valid=%0b pc=%h instr=%h, required 1/10/0abc", if_valid, if_pc, if_instr);
    else n_pass++;
  endtask

  task automatic test_jump_self();
    drive(1'b0, 1'b1, 8'h20, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 8'h20 || imem_addr !== 8'h20 || if_instr !== 16'h2020)
        $display("FAIL jump_self[%0d]: valid=%0b pc=%h addr=%h instr=%h, required 1/20/20/2020",
                 i, if_valid, if_pc, imem_addr, if_instr);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({if_valid, if_instr, if_pc, fetch_cnt, halted, imem_addr} !== 50'h0)
      $display("FAIL async_reset: valid=%0b instr=%h pc=%h cnt=%0d halted=%0b addr=%h, required all zero",
               if_valid, if_instr, if_pc, fetch_cnt, halted, imem_addr);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic       s, r, h;
    logic [7:0] rp;
    int         errs;
    for (int a = 0; a < 256; a++) begin
      mem[a] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) mem[a][15:12] = 4'd2;
    end
    apply_reset();
    model_reset();
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 11) == 0);
      rp = 8'($urandom);
      h  = ($urandom_range(0, 24) == 0);
      drive(s, r, rp, h);
      @(posedge clk);
      model_step(s, r, int'(rp), h);
      #1;
      n_total++;
      if (imem_addr !== 8'(m_pc) || if_valid !== m_valid || if_pc !== 8'(m_ipc) ||
          if_instr !== m_instr || fetch_cnt !== 16'(m_cnt) || halted !== m_halted) begin
        if (errs < 10)
          $display("FAIL random[%0d]: addr=%h valid=%0b pc=%h instr=%h cnt=%0d halted=%0b, required %h/%0b/%h/%h/%0d/%0b",
                   c, imem_addr, if_valid, if_pc, if_instr, fetch_cnt, halted,
                   8'(m_pc), m_valid, 8'(m_ipc), m_instr, m_cnt, m_halted);
        errs++;
      end else n_pass++;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[8'h00] = 16'h0440;
    mem[8'h01] = 16'h460E;
    mem[8'h02] = 16'hB0E1;
    mem[8'h03] = 16'h1111;
    mem[8'h04] = 16'h2000;
    mem[8'h10] = 16'h0ABC;
    mem[8'h20] = 16'h2020;
    mem[8'h40] = 16'h1234;
    mem[8'hFF] = 16'h5678;

    test_reset();
    test_sequential_and_stall();
    test_jump();
    test_redirect_over_stall();
    test_wrap();
    test_halt();
    test_jump_self();
    test_async_reset();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
